// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned modes.
// One shift-add step per cycle. A fixed WIDTH+2 cycle latency runs from accept to the done pulse.
// Signed operands are reduced to magnitudes on accept.
// The sign is reapplied in a single FIX cycle.
//
// Handshake: start is sampled only in IDLE; the accept edge moves the FSM to CALC.
// done is a one-cycle pulse, and product is valid in that same cycle.
// product then holds its value until the next result is written or rst clears it.
// busy is high in CALC and FIX.
// The next start may be accepted in the cycle after DONE.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           ALUcontrol,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 result_neg;
  logic [2*WIDTH-1:0]   acc;

  logic                 signed_mode;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   addend;

  assign dbg_state = state;

  // Operand conditioning for accept, and the shifted partial product for the current step.
  // Negating the most negative value in WIDTH bits yields 2^(WIDTH-1), which is the correct magnitude.
  always_comb begin
    signed_mode = (ALUcontrol != 4'b0001);
    a_mag       = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
    b_mag       = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;
    addend      = {{WIDTH{1'b0}}, mcand} << cnt;
  end

  // Control FSM and datapath; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      product    <= '0;
      acc        <= '0;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      result_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand      <= a_mag;
            mplier     <= b_mag;
            result_neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + addend;
          end
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          product <= result_neg ? (~acc + ONE_2W) : acc;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier (WIDTH=32).
// Directed corner cases plus randomized operations.
// An arithmetic reference model computes each expected product.
// A monitor checks each done pulse against a scoreboard queue.
module tb_seq_multiplier;

  localparam int W   = 32;
  localparam int CLK = 10;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       ALUcontrol;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;
  logic [1:0]       dbg_state;

  always #(CLK/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUcontrol(ALUcontrol),
    .a(a), .b(b), .busy(busy), .done(done), .product(product),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int             done_q[$];
  int             busy_lo = -1;
  int             busy_hi = -1;
  int             next_ok = 0;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check(input string name, input logic [2*W-1:0] actual, input logic [2*W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
    end
  endtask

  // Reference: the exact mathematical product in 2W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] ctrl);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    if (ctrl == 4'b0001) begin
      return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end
    sx = $signed({{W{x[W-1]}}, x});
    sy = $signed({{W{y[W-1]}}, y});
    return sx * sy;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic exp_done;
    logic exp_busy;
    if (!rst) begin
      exp_done = (done_q.size() > 0) && (cyc == done_q[0]);
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("done_timing", {{(2*W-1){1'b0}}, done}, {{(2*W-1){1'b0}}, exp_done});
      check("busy_window", {{(2*W-1){1'b0}}, busy}, {{(2*W-1){1'b0}}, exp_busy});
      if (exp_done) begin
        void'(done_q.pop_front());
        if (exp_q.size() > 0) check("product", product, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the start cycle.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] ctrl, output int c);
    while (cyc < next_ok) @(negedge clk);
    a = x; b = y; ALUcontrol = ctrl; start = 1'b1;
    c = cyc;
    exp_q.push_back(ref_mul(x, y, ctrl));
    done_q.push_back(c + W + 2);
    busy_lo = c + 1;
    busy_hi = c + W + 1;
    next_ok = c + W + 3;
    @(negedge clk);
    start = 1'b0;
    // Inputs move after accept and must not disturb the result.
    a = W'($urandom); b = W'($urandom); ALUcontrol = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int c;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ALUcontrol = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_busy", {{(2*W-1){1'b0}}, busy}, '0);
    check("reset_done", {{(2*W-1){1'b0}}, done}, '0);
    check("reset_product", product, '0);
    rst = 1'b0;
    next_ok = cyc + 1;

    // Unsigned full scale
    issue('1, '1, 4'b0001, c);
    exp_q[0] = 64'hFFFFFFFE00000001;

    // Signed mixed sign
    issue(-32'sd3, 32'd5, 4'b0000, c);
    // Signed minimum squared
    issue(32'h80000000, 32'h80000000, 4'b0000, c);

    // Undefined code, start pulse while busy
    issue('1, '1, 4'b1111, c);
    wait_until(c + 5);
    a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation
    issue(32'd123, 32'd456, 4'b0001, c);
    wait_until(c + 10);
    rst = 1'b1;
    busy_hi = cyc;
    done_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", {{(2*W-1){1'b0}}, busy}, '0);
    check("abort_done", {{(2*W-1){1'b0}}, done}, '0);
    check("abort_product", product, '0);
    rst = 1'b0;
    next_ok = cyc + 1;
    issue(32'd6, 32'd7, 4'b0001, c);

    // Zero operand, then product hold during idle
    issue(32'd0, 32'h80000000, 4'b0000, c);
    wait_until(c + W + 3);
    for (int i = 0; i < 10; i++) begin
      check("hold_product", product, '0);
      @(negedge clk);
    end

    // Randomized operations with random gaps
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ctrl;
      ctrl = ($urandom_range(0, 2) == 0) ? 4'b0001 : 4'($urandom_range(0, 15));
      next_ok = next_ok + $urandom_range(0, 2);
      issue(pick_op(), pick_op(), ctrl, c);
    end

    for (int i = 0; i < 200 && done_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", 64'(done_q.size()), '0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #(CLK * 60000);
    $display("FAIL watchdog cycle=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal values 8..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; accepted only in IDLE.
REQ-005 ALUcontrol  input  4  operation mode from the ALU control decode stage: 4'b0001 = unsigned; every other code = signed (two's complement).
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 busy  output  1  high while a multiply is in progress.
REQ-009 done  output  1  one-cycle pulse; product valid.
REQ-010 product  output  2*WIDTH  full-width result; held until the next accepted start or reset.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
- IDLE -> CALC on start.
- CALC -> FIX after exactly WIDTH CALC cycles.
- FIX -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-012 On accept (IDLE and start=1), the block SHALL latch a, b and the signed/unsigned mode, clear the accumulator and the bit counter, and enter CALC on the next edge.
REQ-013 In signed mode, latching SHALL store the magnitudes |a| and |b| as WIDTH-bit unsigned values and store result_neg = a[MSB] XOR b[MSB]. In unsigned mode, the raw values SHALL be stored and result_neg = 0.
REQ-014 |-2^(WIDTH-1)| SHALL be represented as the unsigned value 2^(WIDTH-1) with no overflow.
REQ-015 Each CALC cycle SHALL perform one shift-add step. If the current multiplier LSB is 1, the multiplicand SHALL be added into the 2*WIDTH accumulator at the counter position. The counter SHALL then increment.
REQ-016 FIX SHALL write product = result_neg ? two's-complement negation of the accumulator : the accumulator.
REQ-017 DONE SHALL drive done=1 for exactly one cycle, with product already valid in that cycle.
REQ-018 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-019 Latency: when start is accepted in cycle 0, done SHALL be high in cycle WIDTH+2. This latency SHALL be independent of operand values and mode.
REQ-020 start SHALL be ignored in CALC, FIX and DONE. Changes to a, b or ALUcontrol after accept SHALL NOT affect the result in progress.
REQ-021 A new start is accepted no earlier than the cycle after DONE. Back-to-back throughput SHALL be one result per WIDTH+3 cycles.
REQ-022 A zero operand SHALL produce product = 0 with the full latency.
REQ-023 The signed result SHALL be exact over the full range, including (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-024 There SHALL be no combinational path from any input to busy, done or product; all three outputs SHALL be registered.

Reset
REQ-025 When rst=1 at a clock edge, the next state SHALL be: state = IDLE, busy = 0, done = 0, product = 0, accumulator, counter and latched operands cleared.
REQ-026 Reset SHALL take priority over start and over every state transition.
REQ-027 A reset applied mid-CALC or mid-FIX SHALL abort the operation, and no done pulse SHALL follow.
REQ-028 The first start accepted after reset is released SHALL behave exactly per REQ-012 to REQ-019.

Verification (WIDTH=32)
REQ-029 Unsigned full-scale:
- Stimulus: ALUcontrol=4'b0001, a=b=32'hFFFFFFFF, start in cycle 0.
- Required: done high in cycle 34 only; product = 64'hFFFFFFFE00000001; busy high in cycles 1..33.
REQ-030 Signed mixed sign:
- Stimulus: ALUcontrol=4'b0000, a=-3, b=5.
- Required: product = 64'hFFFFFFFFFFFFFFF1.
REQ-031 Signed minimum squared:
- Stimulus: ALUcontrol=4'b0000, a=b=32'h80000000.
- Required: product = 64'h4000000000000000.
REQ-032 Undefined code and start-while-busy:
- Stimulus: ALUcontrol=4'b1111, a=b=32'hFFFFFFFF; then start pulsed in cycle 5 with a=7, b=9.
- Required: product = 64'h1 (signed -1*-1); the cycle-5 start is ignored; exactly one done pulse occurs, in cycle 34.
REQ-033 Reset mid-operation:
- Stimulus: rst=1 in cycle 10 of a multiply.
- Required: in cycle 11, busy=0, done=0, product=0, and no done pulse follows.
- Then: a fresh start (unsigned, 6*7) SHALL yield product = 42 at latency 34.
REQ-034 Zero operand and hold:
- Stimulus: signed, a=0, b=32'h80000000.
- Required: product = 0, done in cycle 34; product remains unchanged through 10 further idle cycles.
